// File: rtl/uart_mmio_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register offsets,
// STATUS field positions and serializer states.
package uart_mmio_pkg;

    // Word offsets, compared against mem_addr[3:2].
    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;

    localparam int unsigned STATUS_BUSY      = 0;
    localparam int unsigned STATUS_FULL      = 1;
    localparam int unsigned STATUS_EMPTY     = 2;
    localparam int unsigned STATUS_OVERRUN   = 3;
    localparam int unsigned STATUS_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through output and synchronous flush.
// A push is refused when full, judged before any same-cycle pop.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped 8N1 UART transmitter: register decode, registered read mux,
// TX FIFO and a baud-timed serializer.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd434
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        sel,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_idle
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]    reg_sel;
    logic          wr_en, rd_en;
    logic          fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_dout;
    logic [CW-1:0] fifo_count;

    logic [15:0]   baud_div_q, baud_div_d, div_merged;
    logic          overrun_q, overrun_d;
    logic [31:0]   rdata_q, rdata_d, status;

    tx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [15:0]   baud_cnt_q, baud_cnt_d;
    logic          tx_q, tx_d;
    logic          bit_done, start_frame;

    logic          unused_bits;
    assign unused_bits = ^{mem_addr[31:4], mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

    assign reg_sel   = mem_addr[3:2];
    assign wr_en     = sel && (mem_wstrb != 4'b0000);
    assign rd_en     = sel && mem_rstrb;
    assign fifo_push = wr_en && (reg_sel == REG_TXDATA) && mem_wstrb[0];

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (mem_wdata[7:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        div_merged = baud_div_q;
        if (mem_wstrb[0]) div_merged[7:0]  = mem_wdata[7:0];
        if (mem_wstrb[1]) div_merged[15:8] = mem_wdata[15:8];
        baud_div_d = baud_div_q;
        if (wr_en && (reg_sel == REG_BAUDDIV)) begin
            baud_div_d = (div_merged == 16'd0) ? 16'd1 : div_merged;
        end

        overrun_d = overrun_q;
        if (fifo_push && fifo_full) begin
            overrun_d = 1'b1;
        end else if (wr_en && (reg_sel == REG_STATUS) && mem_wstrb[0]
                     && mem_wdata[STATUS_OVERRUN]) begin
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        status                        = '0;
        status[STATUS_BUSY]           = (state_q != ST_IDLE);
        status[STATUS_FULL]           = fifo_full;
        status[STATUS_EMPTY]          = fifo_empty;
        status[STATUS_OVERRUN]        = overrun_q;
        status[STATUS_COUNT_LSB +: 4] = 4'(fifo_count);

        rdata_d = rdata_q;
        if (rd_en) begin
            case (reg_sel)
                REG_STATUS:  rdata_d = status;
                REG_BAUDDIV: rdata_d = {16'd0, baud_div_q};
                default:     rdata_d = 32'd0;
            endcase
        end
    end

    assign bit_done = (baud_cnt_q == 16'd0);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_idx_d   = bit_idx_q;
        baud_cnt_d  = baud_cnt_q;
        tx_d        = tx_q;
        fifo_pop    = 1'b0;
        start_frame = 1'b0;

        unique case (state_q)
            ST_IDLE: start_frame = !fifo_empty;
            ST_START: begin
                if (bit_done) begin
                    state_d    = ST_DATA;
                    tx_d       = shift_q[0];
                    bit_idx_d  = 3'd0;
                    baud_cnt_d = baud_div_q - 16'd1;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_done) begin
                    baud_cnt_d = baud_div_q - 16'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = ST_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_done) begin
                    // End of stop bit behaves as IDLE so queued frames follow with no gap.
                    state_d     = ST_IDLE;
                    start_frame = !fifo_empty;
                end else begin
                    baud_cnt_d = baud_cnt_q - 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (start_frame) begin
            fifo_pop   = 1'b1;
            shift_d    = fifo_dout;
            baud_cnt_d = baud_div_q - 16'd1;
            tx_d       = 1'b0;
            state_d    = ST_START;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            baud_div_q <= DEFAULT_DIV;
            overrun_q  <= 1'b0;
            rdata_q    <= 32'd0;
            state_q    <= ST_IDLE;
            shift_q    <= 8'd0;
            bit_idx_q  <= 3'd0;
            baud_cnt_q <= 16'd0;
            tx_q       <= 1'b1;
        end else begin
            baud_div_q <= baud_div_d;
            overrun_q  <= overrun_d;
            rdata_q    <= rdata_d;
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_idx_q  <= bit_idx_d;
            baud_cnt_q <= baud_cnt_d;
            tx_q       <= tx_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign uart_tx   = tx_q;
    assign tx_idle   = (state_q == ST_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_mmio.sv
// Directed-plus-random bench for uart_mmio: bus tasks, a line-level frame
// checker and a count/overrun/divisor model derived from the register rules.
module tb_uart_mmio;

    localparam int DEPTH = 8;
    localparam logic [31:0] A_TX = 32'h0, A_ST = 32'h4, A_DIV = 32'h8, A_RSV = 32'hC;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic        uart_tx, tx_idle;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    int          m_count = 0;
    bit          m_ovr   = 1'b0;
    logic [15:0] m_div   = 16'd434;

    uart_mmio #(
        .FIFO_DEPTH  (DEPTH),
        .DEFAULT_DIV (16'd434)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel       (sel),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .uart_tx   (uart_tx),
        .tx_idle   (tx_idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit busy, input int count, input bit ovr);
        logic [31:0] s;
        s        = '0;
        s[0]     = busy;
        s[1]     = (count == DEPTH);
        s[2]     = (count == 0);
        s[3]     = ovr;
        s[11:8]  = 4'(count);
        return s;
    endfunction

    // Push judged against the pre-pop occupancy.
    task automatic model_push();
        if (m_count == DEPTH) m_ovr = 1'b1;
        else m_count++;
    endtask

    // All bus tasks start and end on a negedge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb);
        sel = 1'b1; mem_addr = addr; mem_wdata = data; mem_wstrb = strb;
        @(negedge clk);
        sel = 1'b0; mem_wstrb = 4'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        sel = 1'b1; mem_addr = addr; mem_rstrb = 1'b1;
        @(negedge clk);
        sel = 1'b0; mem_rstrb = 1'b0;
        data = mem_rdata;
    endtask

    task automatic wait_until(input int n);
        chk("sched", {31'd0, cyc <= n}, 32'd1);
        while (cyc < n) @(negedge clk);
    endtask

    // Waits up to budget samples for the start bit, then checks every cycle of the frame.
    task automatic rx_frame(input logic [7:0] b, input int div, input int budget,
                            input string tag);
        int  waited = 0;
        bit  seen   = 1'b0;
        logic [9:0] frame;
        frame = {1'b1, b, 1'b0};
        while (!seen && waited < budget) begin
            @(negedge clk);
            waited++;
            if (uart_tx === 1'b0) seen = 1'b1;
        end
        chk($sformatf("%s start", tag), {31'd0, seen}, 32'd1);
        if (seen) begin
            for (int c = 1; c < 10 * div; c++) begin
                @(negedge clk);
                chk($sformatf("%s cyc%0d", tag, c), {31'd0, uart_tx}, {31'd0, frame[c / div]});
            end
        end
    endtask

    logic [31:0] rd;
    logic [7:0]  burst [9];
    int          t0, div_b, s1;
    bit          quiet;

    initial begin
        @(negedge clk);
        repeat (2) @(negedge clk);
        chk("rst uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("rst tx_idle", {31'd0, tx_idle}, 32'd1);
        chk("rst rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        bus_read(A_ST, rd);  chk("rst status", rd, 32'h4);
        bus_read(A_DIV, rd); chk("rst bauddiv", rd, 32'd434);
        bus_read(A_TX, rd);  chk("txdata reads 0", rd, 32'd0);
        bus_read(A_RSV, rd); chk("reserved reads 0", rd, 32'd0);

        // Single frame 0xA5 at DIV=4, start bit on the edge after the write.
        bus_write(A_DIV, 32'd4, 4'b0011); m_div = 16'd4;
        bus_read(A_DIV, rd); chk("div=4", rd, 32'd4);
        bus_write(A_TX, 32'hA5, 4'b0001);
        rx_frame(8'hA5, 4, 1, "a5");
        @(negedge clk);
        chk("a5 idle after", {31'd0, tx_idle}, 32'd1);
        chk("a5 line high", {31'd0, uart_tx}, 32'd1);

        // Nine random bytes back-to-back: all sent gaplessly, never overruns.
        for (int i = 0; i < 9; i++) burst[i] = 8'($urandom);
        fork
            begin
                for (int i = 0; i < 9; i++) bus_write(A_TX, {24'd0, burst[i]}, 4'b0001);
            end
            begin
                for (int k = 0; k < 9; k++)
                    rx_frame(burst[k], 4, (k == 0) ? 2 : 1, $sformatf("burst%0d", k));
            end
        join
        @(negedge clk);
        chk("burst idle", {31'd0, tx_idle}, 32'd1);
        bus_read(A_ST, rd); chk("burst status", rd, exp_status(0, 0, 0));

        // Fill, overrun, clear, then push on the exact pop cycle of a full FIFO.
        div_b = 16;
        bus_write(A_DIV, div_b, 4'b0011); m_div = 16'(div_b);
        m_count = 0; m_ovr = 0;
        t0 = cyc;
        for (int i = 0; i < 9; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            if (i == 1) b[3] = 1'b0;
            bus_write(A_TX, {24'd0, b}, 4'b0001);
            model_push();
            if (i == 1) m_count--;
        end
        bus_read(A_ST, rd); chk("full status", rd, exp_status(1, m_count, m_ovr));
        for (int i = 0; i < 10; i++) begin
            bus_write(A_TX, $urandom, 4'b0001);
            model_push();
        end
        bus_read(A_ST, rd); chk("overrun status", rd, exp_status(1, m_count, m_ovr));
        bus_write(A_ST, 32'h8, 4'b0001); m_ovr = 1'b0;
        bus_read(A_ST, rd); chk("overrun cleared", rd, exp_status(1, m_count, m_ovr));

        wait_until(t0 + 1 + 10 * div_b);
        bus_write(A_TX, $urandom, 4'b0001);
        model_push(); m_count--;
        bus_read(A_ST, rd); chk("push on pop full", rd, exp_status(1, m_count, m_ovr));

        // Reset in the middle of data bit 3 of the second frame (bit 3 forced 0).
        s1 = t0 + 2 + 10 * div_b;
        wait_until(s1 + 4 * div_b + div_b / 2 - 1);
        chk("bit3 low", {31'd0, uart_tx}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst uart_tx", {31'd0, uart_tx}, 32'd1);
        chk("mid rst tx_idle", {31'd0, tx_idle}, 32'd1);
        chk("mid rst rdata", mem_rdata, 32'd0);
        rst = 1'b0; m_count = 0; m_ovr = 1'b0; m_div = 16'd434;
        bus_read(A_ST, rd); chk("post rst status", rd, exp_status(0, m_count, m_ovr));
        quiet = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || tx_idle !== 1'b1) quiet = 1'b0;
        end
        chk("no frame after rst", {31'd0, quiet}, 32'd1);
        bus_read(A_DIV, rd); chk("post rst div", rd, {16'd0, m_div});

        // Divisor lanes and zero clamp.
        bus_write(A_DIV, 32'd0, 4'b0011); m_div = 16'd1;
        bus_read(A_DIV, rd); chk("div zero->1", rd, 32'd1);
        for (int i = 0; i < 6; i++) begin
            logic [31:0] v;
            logic [3:0]  s;
            logic [15:0] m;
            v = $urandom;
            s = 4'($urandom_range(1, 15));
            m = m_div;
            if (s[0]) m[7:0]  = v[7:0];
            if (s[1]) m[15:8] = v[15:8];
            m_div = (m == 16'd0) ? 16'd1 : m;
            bus_write(A_DIV, v, s);
            bus_read(A_DIV, rd); chk($sformatf("div lanes %0d", i), rd, {16'd0, m_div});
        end

        // Unselected accesses, reserved register, TXDATA without lane 0.
        bus_read(A_ST, rd); chk("status before sel0", rd, exp_status(0, 0, 0));
        sel = 1'b0; mem_addr = A_DIV; mem_rstrb = 1'b1; mem_wdata = 32'h55; mem_wstrb = 4'hF;
        @(negedge clk);
        mem_rstrb = 1'b0; mem_wstrb = 4'h0;
        chk("sel0 rdata hold", mem_rdata, exp_status(0, 0, 0));
        bus_write(A_RSV, 32'hFFFF_FFFF, 4'hF);
        chk("reserved write rdata hold", mem_rdata, exp_status(0, 0, 0));
        bus_read(A_DIV, rd); chk("div after ignored writes", rd, {16'd0, m_div});
        bus_write(A_TX, 32'h3C, 4'b0010);
        @(negedge clk);
        chk("no push w/o lane0", {31'd0, tx_idle}, 32'd1);
        bus_read(A_ST, rd); chk("status final", rd, exp_status(0, 0, 0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
